// File: rtl/game_timer.sv
// game_timer: level-preset MM:SS BCD countdown driving hex3..hex0 and timer_stop.
// Optional GAME_TIMER_WARN_EN adds a blinking warn output for the last ten seconds.
module game_timer #(
  parameter int          CLK_FREQ_HZ = 40_000_000,
  parameter logic [2:0]  PLAY_STATE  = 3'd3,
  parameter logic [2:0]  WON_STATE   = 3'd4,
  parameter logic [2:0]  LOST_STATE  = 3'd5,
  parameter logic [15:0] EASY_TIME   = 16'h0500,
  parameter logic [15:0] MEDIUM_TIME = 16'h0800,
  parameter logic [15:0] HARD_TIME   = 16'h1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] main_state,
  input  logic [1:0] level,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
`ifdef GAME_TIMER_WARN_EN
  output logic [3:0] hex0,
  output logic       timer_stop,
  output logic       warn
`else
  output logic [3:0] hex0,
  output logic       timer_stop
`endif
);
  localparam int PW = $clog2(CLK_FREQ_HZ + 1);
  typedef enum logic [1:0] {IDLE, RUNNING, FROZEN, EXPIRED} state_t;
  state_t      state;
  logic [2:0]  prev_state;
  logic [PW-1:0] pre;
  logic [15:0] val, preset, dec;
  logic        entry, tick, endgame, play, b0, b1, b2;
  assign {hex3, hex2, hex1, hex0} = val;
  assign play    = main_state == PLAY_STATE;
  assign entry   = play && prev_state != PLAY_STATE;
  assign endgame = main_state == WON_STATE || main_state == LOST_STATE;
  assign tick    = pre == PW'(CLK_FREQ_HZ - 1);
  assign preset  = level == 2'b11 ? HARD_TIME : level == 2'b10 ? MEDIUM_TIME : EASY_TIME;
  // Ripple-borrow BCD decrement: 9 for units digits, 5 for seconds tens.
  assign b0 = val[3:0] == 4'd0;
  assign b1 = b0 && val[7:4] == 4'd0;
  assign b2 = b1 && val[11:8] == 4'd0;
  assign dec[3:0]   = b0 ? 4'd9 : val[3:0] - 4'd1;
  assign dec[7:4]   = b0 ? (val[7:4] == 4'd0 ? 4'd5 : val[7:4] - 4'd1) : val[7:4];
  assign dec[11:8]  = b1 ? (val[11:8] == 4'd0 ? 4'd9 : val[11:8] - 4'd1) : val[11:8];
  assign dec[15:12] = b2 ? val[15:12] - 4'd1 : val[15:12];
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev_state <= 3'd0;
      pre        <= '0;
      val        <= 16'h0000;
      timer_stop <= 1'b0;
    end else begin
      prev_state <= main_state;
      if (entry) begin
        val        <= preset;
        pre        <= '0;
        timer_stop <= preset == 16'h0000;
        state      <= preset == 16'h0000 ? EXPIRED : RUNNING;
      end else begin
        case (state)
          RUNNING: begin
            if (endgame) begin
              state <= FROZEN;
              pre   <= '0;
            end else if (!play) begin
              state <= IDLE;
              val   <= 16'h0000;
              pre   <= '0;
            end else begin
              pre <= tick ? '0 : pre + 1'b1;
              if (tick) begin
                val <= dec;
                if (dec == 16'h0000) begin
                  state      <= EXPIRED;
                  timer_stop <= 1'b1;
                end
              end
            end
          end
          FROZEN: if (!endgame && !play) begin
            state <= IDLE;
            val   <= 16'h0000;
          end
          EXPIRED: if (!endgame && !play) begin
            state      <= IDLE;
            val        <= 16'h0000;
            timer_stop <= 1'b0;
          end
          default: val <= 16'h0000;
        endcase
      end
    end
  end
`ifdef GAME_TIMER_WARN_EN
  logic half, run_stay;
  assign half     = pre == PW'(CLK_FREQ_HZ / 2 - 1);
  assign run_stay = state == RUNNING && play && !entry && !(tick && dec == 16'h0000);
  always_ff @(posedge clk) begin
    if (rst) warn <= 1'b0;
    else warn <= run_stay && val <= 16'h0010 ? ((tick || half) ? ~warn : warn) : 1'b0;
  end
`endif
endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: directed scoreboard bench for game_timer at CLK_FREQ_HZ=10.
module tb_game_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] main_state = 3'd0;
  logic [1:0] level = 2'b00;
  logic [3:0] hex3, hex2, hex1, hex0;
  logic       timer_stop;
`ifdef GAME_TIMER_WARN_EN
  logic       warn;
`endif
  int tests = 0;
  int fails = 0;
  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  game_timer #(
    .CLK_FREQ_HZ(10),
    .EASY_TIME(16'h0003),
    .MEDIUM_TIME(16'h0100),
    .HARD_TIME(16'h1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .main_state(main_state),
    .level(level),
    .hex3(hex3),
    .hex2(hex2),
    .hex1(hex1),
    .hex0(hex0),
`ifdef GAME_TIMER_WARN_EN
    .timer_stop(timer_stop),
    .warn(warn)
`else
    .timer_stop(timer_stop)
`endif
  );

  // Expected result is queued when stimulus is applied and popped n cycles later.
  task automatic run(input int n, input string tag, input logic [15:0] v, input logic stop);
    exp_t e;
    logic [16:0] obs;
    sb.push_back('{tag, {v, stop}});
    repeat (n) @(negedge clk);
    e = sb.pop_front();
    obs = {hex3, hex2, hex1, hex0, timer_stop};
    tests++;
    assert (obs === e.v) else begin
      fails++;
      $error("FAIL %s: got hex=%h stop=%b, want hex=%h stop=%b", e.tag, obs[16:1], obs[0], e.v[16:1], e.v[0]);
    end
  endtask

  initial begin
    run(3, "reset", 16'h0000, 1'b0);
    rst = 1'b0;
    run(2, "idle_hold", 16'h0000, 1'b0);
    level = 2'b11; main_state = 3'd3;
    run(1, "load_hard", 16'h1000, 1'b0);
    run(9, "pre_tick", 16'h1000, 1'b0);
    run(1, "all_borrow", 16'h0959, 1'b0);
    level = 2'b00;
    run(10, "second_tick", 16'h0958, 1'b0);
    run(9, "pre_freeze", 16'h0958, 1'b0);
    main_state = 3'd4;
    run(1, "freeze_on_tick", 16'h0958, 1'b0);
    run(15, "frozen_hold", 16'h0958, 1'b0);
    level = 2'b10; main_state = 3'd3;
    run(1, "reload_medium", 16'h0100, 1'b0);
    run(10, "minute_borrow", 16'h0059, 1'b0);
    main_state = 3'd0;
    run(1, "run_to_idle", 16'h0000, 1'b0);
    level = 2'b01; main_state = 3'd3;
    run(1, "load_easy", 16'h0003, 1'b0);
    run(10, "easy_2", 16'h0002, 1'b0);
    run(10, "easy_1", 16'h0001, 1'b0);
    run(9, "pre_expire", 16'h0001, 1'b0);
    run(1, "expire", 16'h0000, 1'b1);
    run(20, "expired_hold", 16'h0000, 1'b1);
    level = 2'b00; main_state = 3'd5;
    run(3, "expired_lost", 16'h0000, 1'b1);
    main_state = 3'd3;
    run(1, "reload_level00", 16'h0003, 1'b0);
    run(30, "expire_again", 16'h0000, 1'b1);
    main_state = 3'd0;
    run(1, "expired_to_idle", 16'h0000, 1'b0);
    level = 2'b11; main_state = 3'd3;
    run(1, "load_hard2", 16'h1000, 1'b0);
    run(14, "mid_run", 16'h0959, 1'b0);
    rst = 1'b1;
    run(1, "reset_mid_run", 16'h0000, 1'b0);
    run(2, "reset_hold", 16'h0000, 1'b0);
    rst = 1'b0;
    run(1, "entry_after_reset", 16'h1000, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
